imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/mips_pkg.sv | 24 ++
 rtl/imem_loader_if.sv | 35 +++
 rtl/imem_loader_byte_packer.sv | 48 ++++
 rtl/imem_loader.sv | 119 +++++++++++
 tb/tb_imem_loader.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state
// encoding, default text-segment base and instruction word width.
package mips_pkg;

  localparam logic [31:0] TEXT_BASE_DEFAULT = 32'h0000_3000;
  localparam int unsigned IM_WORD_W         = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } load_state_e;

  // Shift one byte into the low end of a word; the first byte of a word
  // ends up in the most-significant position after four shifts.
  function automatic logic [IM_WORD_W-1:0] shift_in_byte(
    input logic [IM_WORD_W-1:0] word,
    input logic [7:0]           b
  );
    return {word[IM_WORD_W-9:0], b};
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// The loader side uses the slave modport, the stream source / memory
// side uses the master modport.
interface imem_loader_if
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) ();

  logic [7:0]           s_data;
  logic                 s_valid;
  logic                 s_ready;
  logic                 im_we;
  logic [ADDR_W-1:0]    im_addr;
  logic [IM_WORD_W-1:0] im_wdata;

  modport master (
    output s_data,
    output s_valid,
    input  s_ready,
    input  im_we,
    input  im_addr,
    input  im_wdata
  );

  modport slave (
    input  s_data,
    input  s_valid,
    output s_ready,
    output im_we,
    output im_addr,
    output im_wdata
  );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// Four-byte shift register with a 2-bit byte counter. word_ready flags
// the handshake that completes a word (the fourth byte).
module byte_packer
  import mips_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 shift_en,
  input  logic [7:0]           byte_in,
  output logic [IM_WORD_W-1:0] word_o,
  output logic                 word_ready
);

  logic [1:0]           cnt_q, cnt_d;
  logic [IM_WORD_W-1:0] shreg_q, shreg_d;

  // Next-state: clear at the start of a load, shift on each accepted byte.
  always_comb begin
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    if (clr) begin
      cnt_d   = 2'd0;
      shreg_d = {IM_WORD_W{1'b0}};
    end else if (shift_en) begin
      cnt_d   = cnt_q + 2'd1;
      shreg_d = shift_in_byte(shreg_q, byte_in);
    end else begin
      cnt_d   = cnt_q;
      shreg_d = shreg_q;
    end
  end

  // Counter and shift register flops with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= 2'd0;
      shreg_q <= {IM_WORD_W{1'b0}};
    end else begin
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
    end
  end

  assign word_o     = shreg_q;
  assign word_ready = shift_en && (cnt_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Loads a program from a byte stream into the instruction memory, one
// 32-bit word per write, and holds the CPU in reset until a complete
// program has been written.
module imem_loader
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter logic [31:0] TEXT_BASE = TEXT_BASE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  imem_loader_if.slave      bus,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic [31:0]       base_addr
);

  // Largest load the memory can hold; larger requests are clamped so the
  // word index never wraps inside a single load.
  localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_WORD  = {{ADDR_W{1'b0}}, 1'b1};

  load_state_e          state_q, state_d;
  logic [ADDR_W:0]      count_q, count_d;
  logic [ADDR_W:0]      word_idx_q, word_idx_d;
  logic                 loaded_q, loaded_d;
  logic                 clr_s;
  logic                 shift_en_s;
  logic                 word_ready_s;
  logic [IM_WORD_W-1:0] word_s;

  assign shift_en_s = (state_q == ST_RECV) && bus.s_valid;

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr_s),
    .shift_en   (shift_en_s),
    .byte_in    (bus.s_data),
    .word_o     (word_s),
    .word_ready (word_ready_s)
  );

  // Next-state and datapath update for the load sequencer.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    word_idx_d = word_idx_q;
    loaded_d   = loaded_q;
    clr_s      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          clr_s      = 1'b1;
          word_idx_d = {(ADDR_W+1){1'b0}};
          count_d    = (word_count > MAX_WORDS) ? MAX_WORDS : word_count;
          if (word_count == {(ADDR_W+1){1'b0}}) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RECV;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RECV: begin
        if (word_ready_s) begin
          state_d = ST_WRITE;
        end else begin
          state_d = ST_RECV;
        end
      end
      ST_WRITE: begin
        word_idx_d = word_idx_q + ONE_WORD;
        if ((word_idx_q + ONE_WORD) == count_q) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RECV;
        end
      end
      ST_DONE: begin
        loaded_d = 1'b1;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer state, latched word count, word index and loaded flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      count_q    <= {(ADDR_W+1){1'b0}};
      word_idx_q <= {(ADDR_W+1){1'b0}};
      loaded_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      word_idx_q <= word_idx_d;
      loaded_q   <= loaded_d;
    end
  end

  // All outputs are decoded from registered state only.
  assign bus.s_ready  = (state_q == ST_RECV);
  assign bus.im_we    = (state_q == ST_WRITE);
  assign bus.im_addr  = word_idx_q[ADDR_W-1:0];
  assign bus.im_wdata = word_s;
  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_DONE);
  assign cpu_rst      = ~loaded_q | busy;
  assign base_addr    = TEXT_BASE;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: reset values, back-to-back and stalled
// streams, zero-length load, reload, ignored start, mid-load reset and
// word-count clamping.
module tb_imem_loader;
  import mips_pkg::*;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW:0]   word_count;
  logic          cpu_rst;
  logic          busy;
  logic          done;
  logic [31:0]   base_addr;

  imem_loader_if #(.ADDR_W(AW)) bus ();

  imem_loader #(.ADDR_W(AW), .TEXT_BASE(32'h0000_3000)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .word_count (word_count),
    .bus        (bus),
    .cpu_rst    (cpu_rst),
    .busy       (busy),
    .done       (done),
    .base_addr  (base_addr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event log, sampled on the falling edge.
  int            n_wr = 0, n_acc = 0, n_done = 0, n_bad = 0, n_addr0 = 0;
  logic [AW-1:0] wr_addr [0:63];
  logic [31:0]   wr_data [0:63];
  int            acc_cyc [0:63];
  int            done_cyc [0:15];
  logic [AW-1:0] last_addr;
  logic [31:0]   last_data;

  always @(negedge clk) begin
    if (bus.im_we === 1'b1) begin
      if (n_wr < 64) begin
        wr_addr[n_wr] = bus.im_addr;
        wr_data[n_wr] = bus.im_wdata;
      end
      last_addr = bus.im_addr;
      last_data = bus.im_wdata;
      if (bus.im_addr == '0) n_addr0++;
      n_wr++;
    end
    if (bus.s_valid === 1'b1 && bus.s_ready === 1'b1) begin
      if (n_acc < 64) acc_cyc[n_acc] = cyc;
      n_acc++;
    end
    if (done === 1'b1) begin
      if (n_done < 16) done_cyc[n_done] = cyc;
      n_done++;
    end
    if (bus.im_we === 1'b1 && bus.s_ready === 1'b1) n_bad++;
  end

  int n_cmp = 0, n_mis = 0;
  logic [7:0] stim [0:4095];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [AW:0] wc);
    start      = 1'b1;
    word_count = wc;
    tick();
    start      = 1'b0;
  endtask

  // Present stim[0..nb-1]; advance only on a handshake.
  task automatic run_stream(input int nb, input bit toggle, input int max_cyc, input string tag);
    int   idx = 0;
    int   k = 0;
    logic hs;
    while (idx < nb && k < max_cyc) begin
      bus.s_data  = stim[idx];
      bus.s_valid = toggle ? ((k % 2) == 0) : 1'b1;
      hs = bus.s_valid && bus.s_ready;
      tick();
      if (hs) idx++;
      k++;
    end
    bus.s_valid = 1'b0;
    chk({tag, "_bytes"}, 32'(idx), 32'(nb));
  endtask

  // Wait for done with s_valid held high on junk data.
  task automatic wait_done(input int max_cyc, input string tag);
    int k = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = 8'hFF;
    while (done !== 1'b1 && k < max_cyc) begin
      tick();
      k++;
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_cpurst_in_done"}, 32'(cpu_rst), 32'd1);
    tick();
    bus.s_valid = 1'b0;
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_cpurst_after"}, 32'(cpu_rst), 32'd0);
    chk({tag, "_idle_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int w0, a0, d0, z0;

    rst         = 1'b1;
    start       = 1'b0;
    word_count  = '0;
    bus.s_data  = 8'h00;
    bus.s_valid = 1'b0;
    tick();
    tick();
    chk("rst_s_ready", 32'(bus.s_ready), 32'd0);
    chk("rst_im_we", 32'(bus.im_we), 32'd0);
    chk("rst_im_addr", 32'(bus.im_addr), 32'd0);
    chk("rst_im_wdata", bus.im_wdata, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("base_addr", base_addr, 32'h0000_3000);
    rst = 1'b0;
    tick();

    // Zero-length load: done the cycle after start, no write.
    w0 = n_wr;
    do_start(11'd0);
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_s_ready", 32'(bus.s_ready), 32'd0);
    chk("zero_cpu_rst_hold", 32'(cpu_rst), 32'd1);
    tick();
    chk("zero_done_fall", 32'(done), 32'd0);
    chk("zero_cpu_rst_fall", 32'(cpu_rst), 32'd0);
    chk("zero_no_write", 32'(n_wr - w0), 32'd0);

    // Two words back-to-back.
    w0 = n_wr; a0 = n_acc; d0 = n_done;
    do_start(11'd2);
    chk("a_s_ready", 32'(bus.s_ready), 32'd1);
    chk("a_cpu_rst_rise", 32'(cpu_rst), 32'd1);
    stim[0] = 8'h20; stim[1] = 8'h08; stim[2] = 8'h00; stim[3] = 8'h05;
    stim[4] = 8'hAC; stim[5] = 8'h02; stim[6] = 8'h00; stim[7] = 8'h50;
    run_stream(8, 1'b0, 40, "a");
    wait_done(20, "a");
    chk("a_nwr", 32'(n_wr - w0), 32'd2);
    chk("a_addr0", 32'(wr_addr[w0]), 32'd0);
    chk("a_data0", wr_data[w0], 32'h2008_0005);
    chk("a_addr1", 32'(wr_addr[w0+1]), 32'd1);
    chk("a_data1", wr_data[w0+1], 32'hAC02_0050);
    chk("a_nacc", 32'(n_acc - a0), 32'd8);
    chk("a_done_latency", 32'(done_cyc[d0] - acc_cyc[a0]), 32'd10);

    // Reload with s_valid toggling every cycle.
    w0 = n_wr; a0 = n_acc;
    chk("b_cpu_rst_before", 32'(cpu_rst), 32'd0);
    do_start(11'd1);
    chk("b_cpu_rst_rise", 32'(cpu_rst), 32'd1);
    stim[0] = 8'h12; stim[1] = 8'h34; stim[2] = 8'h56; stim[3] = 8'h78;
    run_stream(4, 1'b1, 30, "b");
    wait_done(20, "b");
    chk("b_nwr", 32'(n_wr - w0), 32'd1);
    chk("b_addr", 32'(wr_addr[w0]), 32'd0);
    chk("b_data", wr_data[w0], 32'h1234_5678);
    chk("b_nacc", 32'(n_acc - a0), 32'd4);

    // start with a new count during RECV is ignored.
    w0 = n_wr;
    do_start(11'd1);
    stim[0] = 8'hAA; stim[1] = 8'hBB;
    run_stream(2, 1'b0, 10, "e1");
    do_start(11'd3);
    chk("e_busy", 32'(busy), 32'd1);
    stim[0] = 8'hCC; stim[1] = 8'hDD;
    run_stream(2, 1'b0, 10, "e2");
    wait_done(20, "e");
    tick();
    tick();
    chk("e_stays_idle", 32'(busy), 32'd0);
    chk("e_nwr", 32'(n_wr - w0), 32'd1);
    chk("e_data", wr_data[w0], 32'hAABB_CCDD);

    // Reset two bytes into a 3-word load.
    w0 = n_wr;
    do_start(11'd3);
    stim[0] = 8'h11; stim[1] = 8'h22;
    run_stream(2, 1'b0, 10, "d1");
    rst         = 1'b1;
    bus.s_valid = 1'b1;
    tick();
    rst = 1'b0;
    chk("d_im_we", 32'(bus.im_we), 32'd0);
    chk("d_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("d_busy", 32'(busy), 32'd0);
    chk("d_s_ready", 32'(bus.s_ready), 32'd0);
    chk("d_im_wdata", bus.im_wdata, 32'd0);
    tick();
    tick();
    tick();
    bus.s_valid = 1'b0;
    chk("d_no_write", 32'(n_wr - w0), 32'd0);
    chk("d_still_idle", 32'(busy), 32'd0);
    do_start(11'd1);
    stim[0] = 8'h01; stim[1] = 8'h02; stim[2] = 8'h03; stim[3] = 8'h04;
    run_stream(4, 1'b0, 20, "d2");
    wait_done(20, "d");
    chk("d_nwr", 32'(n_wr - w0), 32'd1);
    chk("d_addr", 32'(wr_addr[w0]), 32'd0);
    chk("d_data", wr_data[w0], 32'h0102_0304);

    // Oversized count clamps to the full memory without wrapping.
    w0 = n_wr; z0 = n_addr0;
    for (int i = 0; i < 4096; i++) stim[i] = 8'(i);
    do_start(11'h7FF);
    run_stream(4096, 1'b0, 6000, "c");
    wait_done(20, "c");
    chk("c_nwr", 32'(n_wr - w0), 32'd1024);
    chk("c_last_addr", 32'(last_addr), 32'd1023);
    chk("c_last_data", last_data, 32'hFCFD_FEFF);
    chk("c_addr0_once", 32'(n_addr0 - z0), 32'd1);

    chk("no_ready_in_write", 32'(n_bad), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
